// File: rtl/pwm_duty_sequencer_if.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer_if
//   Register-write bus and PWM-core handshake for pwm_duty_sequencer.
//   master : write decode / PWM counter side (drives writes and period_end)
//   slave  : the sequencer (drives duty/period/busy/done)
//   Signals:
//     wr_en      1      register write strobe, one cycle per write
//     wr_addr    2      0 TARGET, 1 STEP, 2 PERIOD, 3 CTRL
//     wr_data    WIDTH  write data
//     period_end 1      one-cycle pulse on the PWM counter wrap cycle
//     duty_out   WIDTH  live duty to the comparator
//     period_out WIDTH  live period to the counter
//     busy       1      high while ramping
//     done       1      one-cycle pulse when the ramp reaches its target
// ---------------------------------------------------------------------------
interface pwm_duty_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             period_end;
    logic [WIDTH-1:0] duty_out;
    logic [WIDTH-1:0] period_out;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, period_end,
        input  duty_out, period_out, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, period_end,
        output duty_out, period_out, busy, done
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer
//   Sequences the duty and period values of the PWM core. Byte-wide register
//   writes program TARGET, STEP and a PERIOD shadow; a START command ramps the
//   live duty toward TARGET by STEP, one step per PWM period. Duty and period
//   only ever change on the edge that samples period_end, so the PWM output
//   cannot glitch mid-period.
//   Ports:
//     i_clk    system clock, rising edge
//     i_rst_n  synchronous active-low reset
//     i_ena    design enable; low freezes all state and masks done
//     bus      pwm_duty_sequencer_if.slave (writes, period_end, outputs)
// ---------------------------------------------------------------------------
module pwm_duty_sequencer #(
    parameter int WIDTH      = 8,
    parameter int RST_PERIOD = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ena,
    pwm_duty_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0]       A_TARGET = 2'd0;
    localparam logic [1:0]       A_STEP   = 2'd1;
    localparam logic [1:0]       A_PERIOD = 2'd2;
    localparam logic [1:0]       A_CTRL   = 2'd3;
    localparam logic [WIDTH-1:0] P_RST    = WIDTH'(RST_PERIOD);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_period_sh;
    logic             r_busy;
    logic             r_done;

    logic             w_wr;
    logic             w_pe;
    logic             w_start;
    logic             w_abort;
    logic             w_up;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_duty_x;
    logic [WIDTH:0]   w_tgt_x;
    logic [WIDTH:0]   w_gap;
    logic [WIDTH:0]   w_next_x;
    logic             w_sat;
    logic [WIDTH-1:0] w_next;

    // Enable gates every input event; with i_ena low nothing is sampled.
    assign w_wr    = i_ena & bus.wr_en;
    assign w_pe    = i_ena & bus.period_end;
    assign w_start = w_wr && (bus.wr_addr == A_CTRL) && bus.wr_data[0];
    assign w_abort = w_wr && (bus.wr_addr == A_CTRL) && bus.wr_data[1];

    // Step arithmetic at WIDTH+1 bits. The move saturates at the target when
    // the step covers the remaining gap, so the result never overshoots or
    // wraps past 0 / 2^WIDTH-1. A programmed STEP of 0 behaves as 1.
    always_comb begin
        w_step_x = {1'b0, (r_step == '0) ? ONE : r_step};
        w_duty_x = {1'b0, r_duty};
        w_tgt_x  = {1'b0, r_target};
        w_up     = (r_duty < r_target);
        w_gap    = w_up ? (w_tgt_x - w_duty_x) : (w_duty_x - w_tgt_x);
        w_sat    = (w_step_x >= w_gap);
        w_next_x = w_up ? (w_duty_x + w_step_x) : (w_duty_x - w_step_x);
        w_next   = w_sat ? r_target : w_next_x[WIDTH-1:0];
    end

    // Register file, period pipeline and ramp FSM. Non-blocking updates mean
    // a write landing on the same edge as period_end is only seen from the
    // following period_end onward.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_duty      <= '0;
            r_period    <= P_RST;
            r_target    <= '0;
            r_step      <= ONE;
            r_period_sh <= P_RST;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (!i_ena) begin
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_pe)
                r_period <= r_period_sh;

            if (w_wr) begin
                case (bus.wr_addr)
                    A_TARGET: r_target    <= bus.wr_data;
                    A_STEP:   r_step      <= bus.wr_data;
                    A_PERIOD: r_period_sh <= bus.wr_data;
                    default:  ;  // CTRL is a command, not stored
                endcase
            end

            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_start) begin
                        r_state <= ST_RAMP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    // Abort wins over a coinciding boundary: duty is frozen.
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_pe) begin
                        r_duty <= w_next;
                        if (w_sat) begin
                            r_state <= ST_HOLD;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.duty_out   = r_duty;
    assign bus.period_out = r_period;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done & i_ena;

endmodule
